// File: rtl/wdt_multi.sv
// wdt_multi: multi-channel watchdog / interval timer on the IBUS.
//
// Each of CH channels has a CNT_W-bit up-counter with auto-reload, an interval
// interrupt (CSR.OVF) and a watchdog mode that, on overflow, emits a WDTOVF_N
// low pulse of OVF_LEN CE_R cycles and optionally a PRES/MRES pulse of RST_LEN
// CE_R cycles. Channel c occupies BASE + 16*c: +0 CSR, +4 CNT, +8 RLD, +C RSTCSR.
//
// Ports:
//   CLK, RST        clock, asynchronous active-high reset
//   CE_R, CE_F      rising/falling phase clock enables (CE_F only for read capture)
//   RES_N           synchronous soft reset, sampled on CE_R
//   PRESC_CE        prescaler ticks, selected per channel by CSR.CKS
//   IBUS_*          32-bit register bus; BUSY is always 0, ACT flags a window hit
//   ITI_IRQ         per-channel interval interrupt (CSR.OVF)
//   WDTOVF_N        low while any channel's overflow pulse is active
//   PRES, MRES      power-on / manual reset requests, OR over channels
module wdt_multi #(
   parameter int unsigned CH      = 2,
   parameter int unsigned CNT_W   = 8,
   parameter logic [31:0] BASE    = 32'hFFFFFE80,
   parameter int unsigned OVF_LEN = 128,
   parameter int unsigned RST_LEN = 512
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CE_R,
   input  logic          CE_F,
   input  logic          RES_N,
   input  logic [7:0]    PRESC_CE,
   input  logic [31:0]   IBUS_A,
   input  logic [31:0]   IBUS_DI,
   output logic [31:0]   IBUS_DO,
   input  logic [3:0]    IBUS_BA,
   input  logic          IBUS_WE,
   input  logic          IBUS_REQ,
   output logic          IBUS_BUSY,
   output logic          IBUS_ACT,
   output logic [CH-1:0] ITI_IRQ,
   output logic          WDTOVF_N,
   output logic          PRES,
   output logic          MRES
);

   localparam logic [31:0] WIN     = 32'(16 * CH);
   localparam int unsigned OW      = $clog2(OVF_LEN + 1);
   localparam int unsigned RW      = $clog2(RST_LEN + 1);
   localparam logic [7:0]  KEY_CNT = 8'h5A;
   localparam logic [7:0]  KEY_CSR = 8'hA5;

   logic [31:0] off;
   logic        reg_sel;
   logic [2:0]  sel_ch;
   logic [1:0]  sel_reg;
   logic        wr_en;
   logic [7:0]  key;

   logic [CH-1:0][31:0] rd_word;
   logic [CH-1:0]       ovf_act;
   logic [CH-1:0]       pres_req;
   logic [CH-1:0]       mres_req;
   logic [31:0]         rd_mux;
   logic [31:0]         rd_q;

   // Byte enables are ignored; all accesses are full 32-bit words.
   logic unused_bits;
   assign unused_bits = ^{IBUS_BA, IBUS_DI};

   // Subtraction never wraps once IBUS_A >= BASE, so one compare bounds the window.
   assign off     = IBUS_A - BASE;
   assign reg_sel = (IBUS_A >= BASE) && (off < WIN);
   assign sel_ch  = off[6:4];
   assign sel_reg = off[3:2];
   assign wr_en   = reg_sel && IBUS_WE && IBUS_REQ;
   assign key     = IBUS_DI[31:24];

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic             ovf_q, wtit_q, tme_q;
      logic [2:0]       cks_q;
      logic [CNT_W-1:0] cnt_q, rld_q;
      logic             wovf_q, rste_q, rsts_q;
      logic             tick_q;
      logic [OW-1:0]    ovf_pls_q;
      logic [RW-1:0]    rst_pls_q;
      logic             rst_sel_q;
      logic             ch_wr, wr_csr, wr_cnt, wr_rld, wr_rst;
      logic             wrap, ovf_set, wdt_evt;
      logic [31:0]      word;

      assign ch_wr   = wr_en && (sel_ch == 3'(c));
      assign wr_csr  = ch_wr && (sel_reg == 2'd0) && (key == KEY_CSR);
      assign wr_cnt  = ch_wr && (sel_reg == 2'd1) && (key == KEY_CNT);
      assign wr_rld  = ch_wr && (sel_reg == 2'd2) && (key == KEY_CNT);
      assign wr_rst  = ch_wr && (sel_reg == 2'd3) && (key == KEY_CSR);

      assign wrap    = tick_q && tme_q && (&cnt_q);
      assign ovf_set = wrap && !wtit_q;
      assign wdt_evt = wrap && wtit_q;

      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            {ovf_q, wtit_q, tme_q} <= 3'b000;
            cks_q     <= 3'd0;
            cnt_q     <= '0;
            rld_q     <= '0;
            {wovf_q, rste_q, rsts_q} <= 3'b000;
            tick_q    <= 1'b0;
            ovf_pls_q <= '0;
            rst_pls_q <= '0;
            rst_sel_q <= 1'b0;
         end else if (CE_R) begin
            if (!RES_N) begin
               {ovf_q, wtit_q, tme_q} <= 3'b000;
               cks_q     <= 3'd0;
               cnt_q     <= '0;
               rld_q     <= '0;
               {wovf_q, rste_q, rsts_q} <= 3'b000;
               tick_q    <= 1'b0;
               ovf_pls_q <= '0;
               rst_pls_q <= '0;
               rst_sel_q <= 1'b0;
            end else begin
               tick_q <= PRESC_CE[cks_q];

               // Bus write wins over the counter's own update.
               if (wr_cnt) begin
                  cnt_q <= IBUS_DI[CNT_W-1:0];
               end else if (tick_q) begin
                  if (!tme_q)      cnt_q <= '0;
                  else if (&cnt_q) cnt_q <= rld_q;
                  else             cnt_q <= cnt_q + CNT_W'(1);
               end

               if (wr_rld) rld_q <= IBUS_DI[CNT_W-1:0];

               // OVF/WOVF are clear-only from software; a hardware set always wins.
               if (wr_csr) begin
                  {wtit_q, tme_q} <= IBUS_DI[6:5];
                  cks_q           <= IBUS_DI[2:0];
                  ovf_q           <= (ovf_q & IBUS_DI[7]) | ovf_set;
               end else if (wdt_evt) begin
                  {ovf_q, wtit_q, tme_q} <= 3'b000;
                  cks_q                  <= 3'd0;
               end else begin
                  ovf_q <= ovf_q | ovf_set;
               end

               if (wr_rst) begin
                  {rste_q, rsts_q} <= IBUS_DI[6:5];
                  wovf_q           <= (wovf_q & IBUS_DI[7]) | wdt_evt;
               end else begin
                  wovf_q <= wovf_q | wdt_evt;
               end

               if (wdt_evt)              ovf_pls_q <= OW'(OVF_LEN);
               else if (ovf_pls_q != '0) ovf_pls_q <= ovf_pls_q - OW'(1);

               if (wdt_evt && rste_q) begin
                  rst_pls_q <= RW'(RST_LEN);
                  rst_sel_q <= rsts_q;
               end else if (rst_pls_q != '0) begin
                  rst_pls_q <= rst_pls_q - RW'(1);
               end
            end
         end
      end

      always_comb begin
         word = 32'h0;
         case (sel_reg)
            2'd0:    word = {24'h0, ovf_q, wtit_q, tme_q, 2'b11, cks_q};
            2'd1:    word = 32'(cnt_q);
            2'd2:    word = 32'(rld_q);
            default: word = {24'h0, wovf_q, rste_q, rsts_q, 5'h1F};
         endcase
      end

      assign rd_word[c]  = word;
      assign ITI_IRQ[c]  = ovf_q;
      assign ovf_act[c]  = (ovf_pls_q != '0);
      assign pres_req[c] = (rst_pls_q != '0) && !rst_sel_q;
      assign mres_req[c] = (rst_pls_q != '0) && rst_sel_q;
   end

   always_comb begin
      rd_mux = 32'h0;
      for (int i = 0; i < CH; i++) begin
         if (sel_ch == 3'(i)) rd_mux = rd_word[i];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_q <= 32'h0;
      end else if (CE_F && reg_sel && !IBUS_WE && IBUS_REQ) begin
         rd_q <= rd_mux;
      end
   end

   assign IBUS_DO   = reg_sel ? rd_q : 32'h0;
   assign IBUS_BUSY = 1'b0;
   assign IBUS_ACT  = reg_sel;
   assign WDTOVF_N  = ~(|ovf_act);
   assign PRES      = |pres_req;
   assign MRES      = |mres_req;

endmodule

// File: doc/wdt_multi.md
# wdt_multi

Parametrised multi-channel watchdog/interval timer for the SH7604 on-chip peripheral bus. It is the successor to the single 8-bit WDT and provides `CH` independent channels, each with:
- a counter of configurable width;
- an auto-reload register;
- its own interval IRQ;
- watchdog-mode overflow and reset-request pulses whose lengths are set by counted CE_R cycles.

The block sits on the IBUS beside the other on-chip peripherals. Its PRES/MRES outputs feed the reset controller.

## Interface
Parameters:
- `CH`, default 2: number of timer channels (1–8).
- `CNT_W`, default 8: counter and reload width (8–16).
- `BASE`, default 32'hFFFFFE80: base address of the register window. Each channel uses a 16-byte stride.
- `OVF_LEN`, default 128: length of the WDTOVF_N low pulse, in CE_R cycles.
- `RST_LEN`, default 512: length of the PRES/MRES pulse, in CE_R cycles.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: reset. Asynchronous, active-high.
- `CE_R` in 1: rising-phase clock enable. All state advances only when it is 1.
- `CE_F` in 1: falling-phase clock enable. Used only for read data.
- `RES_N` in 1: synchronous soft reset to init values, sampled on CE_R.
- `PRESC_CE` in 8: prescaler ticks {÷8192, ÷4096, ÷1024, ÷512, ÷256, ÷128, ÷64, ÷2}; bit 0 is ÷2.
- `IBUS_A` in 32: bus address.
- `IBUS_DI` in 32: bus write data.
- `IBUS_DO` out 32: bus read data.
- `IBUS_BA` in 4: byte enables. Ignored; all accesses are 32-bit.
- `IBUS_WE` in 1: write enable.
- `IBUS_REQ` in 1: bus request.
- `IBUS_BUSY` out 1: constant 0.
- `IBUS_ACT` out 1: the address hits the window.
- `ITI_IRQ` out CH: per-channel interval interrupt, equal to CSR.OVF.
- `WDTOVF_N` out 1: AND of the per-channel overflow pulses, active low.
- `PRES` out 1: OR over channels of the power-on reset request.
- `MRES` out 1: OR over channels of the manual reset request.

## Operation
Register map: channel c is at `BASE + 16*c`.
- +0 CSR: [7] OVF, [6] WTIT, [5] TME, [4:3] read as 1, [2:0] CKS. Init 0x18.
- +4 CNT: [CNT_W-1:0]. Init 0.
- +8 RLD: [CNT_W-1:0]. Init 0.
- +C RSTCSR: [7] WOVF, [6] RSTE, [5] RSTS, [4:0] read as 1. Init 0x1F.
- Unused bits read as 0.

Write protection: a write takes effect only if the key in DI[31:24] matches the register.
- CNT and RLD require key 0x5A. The value is taken from DI[CNT_W-1:0].
- CSR requires key 0xA5. DI[6:0] is written. OVF can only be cleared: DI[7]=0 clears it, DI[7]=1 leaves it unchanged.
- RSTCSR requires key 0xA5. RSTE and RSTS take DI[6:5]. WOVF can only be cleared: DI[7]=0 clears it.
- Writes with a wrong key, and writes to addresses outside the window, have no effect.

Tick selection: per channel, `tick = PRESC_CE[CKS]` is registered on CE_R.

Counting and overflow, on each registered tick:
- If TME=0, CNT is forced to 0.
- If TME=1, CNT increments.
- At CNT = all-ones with TME=1, the next tick sets CNT to RLD. This wraps to RLD, not 0.
- Overflow in interval mode (WTIT=0): set OVF.
- Overflow in watchdog mode (WTIT=1):
  - set WOVF;
  - CSR returns to 0x18 (timer stops);
  - start the channel's OVF pulse counter at OVF_LEN;
  - if RSTE=1, also start its reset pulse counter at RST_LEN, and latch RSTS to choose PRES (RSTS=0) or MRES (RSTS=1).

Pulses:
- WDTOVF_N is low while any channel's OVF pulse counter is nonzero.
- PRES/MRES are high while the channel's reset pulse counter is nonzero.
- A new overflow during an active pulse reloads that counter, restarting the pulse.

Simultaneous events within one CE_R cycle:
- A bus write to CNT/CSR overrides the counter's update of the same field.
- An OVF or WOVF set beats a software clear, so no event is lost.
- RES_N=0 overrides everything: all registers go to init, pulses are cancelled, outputs go idle.

## Timing
- RST asserted: all registers are at init; IBUS_DO=0, ITI_IRQ=0, WDTOVF_N=1, PRES=0, MRES=0.
- A tick seen in CE_R cycle n changes CNT in CE_R cycle n+1.
- Writes commit on the CE_R cycle in which REG_SEL, IBUS_WE and IBUS_REQ are all high.
- Reads are captured on CE_F when REG_SEL, !IBUS_WE and IBUS_REQ are high. IBUS_DO shows the captured data while REG_SEL is high, otherwise 0.
- ITI_IRQ goes high in the same cycle OVF is set.
- WDTOVF_N goes low in the overflow cycle and stays low for exactly OVF_LEN CE_R cycles.
- PRES/MRES go high in the overflow cycle and stay high for exactly RST_LEN CE_R cycles.

## Test plan
- Reset values: read CSR, CNT, RLD, RSTCSR of ch0 → 0x18, 0, 0, 0x1F.
- Key check: write 0x5A0000F0 to CNT → reads 0xF0. Write 0x330000AA to CNT → still 0xF0.
- Interval mode with reload: RLD=0x80, CNT=0xFE, CSR=0xA5000020 (CKS=÷2) → after 2 ticks CNT=0x80, ITI_IRQ[0]=1. Write 0xA5000020 (OVF bit 0) → ITI_IRQ[0]=0.
- Watchdog reset: RSTCSR=0xA5000040, CSR WTIT=1 TME=1, CNT=0xFF → next tick: WDTOVF_N low for 128 cycles, PRES high for 512 cycles, WOVF=1, CSR=0x18. With RSTS=1, MRES pulses instead of PRES.
- Collision: overflow and an OVF-clear write in the same cycle → OVF=1. A CNT write coinciding with a tick → CNT equals the written value.
- Multi-channel (CH=2, CNT_W=16): ch1 at BASE+16 overflows in watchdog mode while ch0 runs in interval mode → only ch1's WOVF is set, ch0 keeps counting, WDTOVF_N pulses once.
